clkdiv_multi_led: RTL and testbench
===================================

// Module: clkdiv_multi_led
// PURPOSE
//  Parametrised N-channel programmable clock divider for LED drive. Each channel
//  divides clk by a per-channel selectable ratio (power-of-two ladder), with an
//  enable and a one-cycle period-done strobe. Sits between the board clock and
//  the LED/segment drivers; outputs are registered, 50% duty, glitch-free on sel change.
// PARAMETERS
//  CH         4   number of independent channels
//  SEL_W      2   width of each channel's ratio select (2**SEL_W ratios)
//  BASE_HALF  1   half-period in clk cycles at sel=0 (>=1)
//  CNT_W      16  counter width; must hold (BASE_HALF<<(2**SEL_W-1))-1, elaboration error otherwise
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  reset        in   1         asynchronous, active-low reset
//  en           in   CH        per-channel enable
//  sel          in   CH*SEL_W  per-channel ratio select; channel i = sel[i*SEL_W +: SEL_W]
//  clkOut       out  CH        divided outputs, registered
//  period_done  out  CH        1-cycle pulse when channel completes a full period
// BEHAVIOUR
//  - Half-period H(s) = BASE_HALF << s clk cycles; output period = 2*H(s), duty 50%.
//  - Per channel state: cnt[CNT_W], out, sel_act[SEL_W] (latched active select).
//  - reset low (async): cnt=0, clkOut=0, period_done=0, sel_act=0, all channels.
//  - en=0: next edge cnt=0, clkOut=0, period_done=0, sel_act<=sel (clean restart).
//    Dropping en while clkOut=1 forces clkOut low at the next edge (short high allowed).
//  - en=1: if cnt==H(sel_act)-1 -> cnt<=0, clkOut<=~clkOut; else cnt<=cnt+1.
//  - Falling toggle (clkOut 1->0): period_done pulses 1 in the same cycle clkOut goes 0,
//    and sel_act<=sel. sel changes are applied ONLY here -> no truncated/runt periods.
//  - sel change mid-period: ignored until current period ends; multiple changes within
//    one period: value present at the falling-toggle edge wins.
//  - Latency: first rising clkOut at the H-th rising clk edge with en=1 (sel sampled while en=0).
//  - Channels fully independent; no shared counter; simultaneous toggles allowed.
//  - Reset mid-period: outputs 0 immediately (async), restart as from en rising after release.
//  - cnt compare uses CNT_W-bit unsigned; H computed at full CNT_W, no truncation.
// STRUCTURE
//  - Shared package clkdiv_pkg: function half_period(sel, BASE_HALF) and SEL_W/CNT_W
//    legality check constant.
//  - Sub-module clkdiv_chan (one channel: cnt, out, sel_act, strobe); top instantiates
//    CH copies via generate and slices en/sel/outputs.
// TESTING
//  1 reset low 3 cycles, en=0 -> all clkOut=0, period_done=0; reset async-asserted while
//    clkOut=1 -> clkOut=0 before next clk edge.
//  2 BASE_HALF=1, ch0 sel=0 en=1 -> clkOut toggles every cycle (period 2), period_done
//    every 2nd cycle coincident with clkOut 1->0.
//  3 ch0 sel=3 -> high 8 cycles, low 8 cycles; change sel to 1 at cycle 3 of high phase
//    -> current 16-cycle period completes, next period is 4 cycles.
//  4 en dropped mid high phase -> clkOut=0 next edge, no period_done; en re-raised with
//    sel=2 -> first rising edge on 4th enabled clk edge.
//  5 CH=4, sel={3,2,1,0} all en -> periods 16,8,4,2 concurrently; ch1 disable leaves
//    others' phase unchanged.
//  6 CH=2 SEL_W=3 BASE_HALF=5 -> sel=7 gives half-period 640 cycles; CNT_W=9 fails elaboration.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared helpers for the multi-channel LED clock divider: half-period ladder and
// the configuration legality check evaluated at elaboration.
package clkdiv_pkg;

  function automatic longint unsigned half_period(input int unsigned s,
                                                  input int unsigned base);
    return longint'(base) << s;
  endfunction

  // Largest terminal count (BASE_HALF << (2**SEL_W-1)) - 1 must fit in CNT_W bits.
  function automatic bit cnt_w_ok(input int unsigned cnt_w,
                                  input int unsigned sel_w,
                                  input int unsigned base);
    longint unsigned w_max;
    w_max = half_period((32'd1 << sel_w) - 32'd1, base) - 64'd1;
    if (base < 1) return 1'b0;
    if (cnt_w >= 64) return 1'b1;
    return w_max < (64'd1 << cnt_w);
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, registered output, period-done strobe
// and the active ratio select, which only moves at a period boundary.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned BASE_HALF = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             clkOut,
  output logic             period_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel_act;
  logic             r_out;
  logic             r_pd;
  logic [CNT_W-1:0] w_half_m1;

  assign w_half_m1 = CNT_W'(half_period(int'(r_sel_act), BASE_HALF) - 64'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_pd      <= 1'b0;
      r_sel_act <= '0;
    end else if (!en) begin
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_pd      <= 1'b0;
      r_sel_act <= sel;
    end else if (r_cnt == w_half_m1) begin
      r_cnt <= '0;
      r_out <= ~r_out;
      r_pd  <= r_out;
      // New ratio takes effect only on the falling toggle, so no runt periods.
      if (r_out) r_sel_act <= sel;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_pd  <= 1'b0;
    end
  end

  assign clkOut      = r_out;
  assign period_done = r_pd;

endmodule

// File: rtl/clkdiv_multi_led.sv
// N-channel programmable clock divider for LED drive; each channel is an
// independent clkdiv_chan fed from its slice of en/sel.
module clkdiv_multi_led
  import clkdiv_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned BASE_HALF = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH-1:0]       en,
  input  logic [CH*SEL_W-1:0] sel,
  output logic [CH-1:0]       clkOut,
  output logic [CH-1:0]       period_done
);

  localparam bit CFG_OK = cnt_w_ok(CNT_W, SEL_W, BASE_HALF);

  if (!CFG_OK) begin : g_bad_cfg
    $error("clkdiv_multi_led: CNT_W too small for largest half-period or BASE_HALF < 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    clkdiv_chan #(
      .SEL_W     (SEL_W),
      .BASE_HALF (BASE_HALF),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .en          (en[i]),
      .sel         (sel[i*SEL_W +: SEL_W]),
      .clkOut      (clkOut[i]),
      .period_done (period_done[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi_led.sv
// Bench for clkdiv_multi_led: vector table, hand-written corner sequences and
// randomized run against a period-level reference model; second instance for wide ratios.
module tb_clkdiv_multi_led;

  localparam int CH        = 4;
  localparam int SEL_W     = 2;
  localparam int BASE_HALF = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic [7:0] sel;
  logic [3:0] clkOut, pd;
  logic [1:0] en2;
  logic [5:0] sel2;
  logic [1:0] clkOut2, pd2;

  int total = 0;
  int bad   = 0;

  // Model: edges elapsed in current period and its half-period length.
  int         mk[CH];
  int         mh[CH];
  logic [3:0] mo, mp;

  clkdiv_multi_led #(.CH(4), .SEL_W(2), .BASE_HALF(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel),
    .clkOut(clkOut), .period_done(pd)
  );

  clkdiv_multi_led #(.CH(2), .SEL_W(3), .BASE_HALF(5), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .sel(sel2),
    .clkOut(clkOut2), .period_done(pd2)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hp(input int s);
    return BASE_HALF << s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mk[c] = 0;
      mh[c] = hp(0);
    end
    mo = '0;
    mp = '0;
  endtask

  // Period n: low for edges 1..H-1, high for edges H..2H-1, ends at edge 2H.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int s;
      s = int'(sel[c*SEL_W +: SEL_W]);
      if (!reset) begin
        mk[c] = 0; mh[c] = hp(0); mo[c] = 1'b0; mp[c] = 1'b0;
      end else if (!en[c]) begin
        mk[c] = 0; mh[c] = hp(s); mo[c] = 1'b0; mp[c] = 1'b0;
      end else begin
        mk[c]++;
        mp[c] = 1'b0;
        if (mk[c] == 2 * mh[c]) begin
          mk[c] = 0;
          mp[c] = 1'b1;
          mh[c] = hp(s);
        end
        mo[c] = (mk[c] >= mh[c]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_clkOut", 32'(clkOut), 32'(mo));
    chk("model_pd", 32'(pd), 32'(mp));
  endtask

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic       clk;
    logic       pd;
  } vec_t;

  vec_t tv[19];
  logic o[21];
  logic p[21];
  int   npd[CH];

  initial begin
    tv[0]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 2'd0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 2'd0, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 2'd0, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 2'd2, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[10] = '{1'b0, 2'd2, 1'b0, 1'b0};
    tv[11] = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[12] = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[13] = '{1'b1, 2'd2, 1'b0, 1'b0};
    tv[14] = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[15] = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[16] = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[17] = '{1'b1, 2'd2, 1'b1, 1'b0};
    tv[18] = '{1'b1, 2'd2, 1'b0, 1'b1};

    reset = 1'b0; en = '0; sel = '0; en2 = '0; sel2 = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_clkOut", 32'(clkOut), 32'd0);
    chk("reset_pd", 32'(pd), 32'd0);
    chk("reset_clkOut2", 32'(clkOut2), 32'd0);
    chk("reset_pd2", 32'(pd2), 32'd0);
    reset = 1'b1;

    // Table: ch0 at ratio 0, then en drop mid-high and restart at ratio 2.
    for (int i = 0; i < 19; i++) begin
      en  = {3'b0, tv[i].en};
      sel = {6'b0, tv[i].sel};
      tick();
      chk($sformatf("vec%0d_clk", i), 32'(clkOut), 32'({3'b0, tv[i].clk}));
      chk($sformatf("vec%0d_pd", i), 32'(pd), 32'({3'b0, tv[i].pd}));
    end

    // Ratio 3 with a switch to ratio 1 during the 3rd high cycle.
    en = '0; sel = 8'd3;
    tick();
    en = 4'b0001;
    for (int n = 1; n <= 20; n++) begin
      if (n == 11) sel = 8'd1;
      tick();
      o[n] = clkOut[0];
      p[n] = pd[0];
    end
    chk("s3_low7", 32'(o[7]), 32'd0);
    chk("s3_rise8", 32'(o[8]), 32'd1);
    chk("s3_high15", 32'(o[15]), 32'd1);
    chk("s3_fall16", 32'({o[16], p[16]}), 32'b01);
    chk("s3_low17", 32'(o[17]), 32'd0);
    chk("s3_rise18", 32'(o[18]), 32'd1);
    chk("s3_high19", 32'(o[19]), 32'd1);
    chk("s3_fall20", 32'({o[20], p[20]}), 32'b01);

    // All channels concurrently at ratios 0..3, then ch1 disabled for a while.
    en = '0; sel = {2'd3, 2'd2, 2'd1, 2'd0};
    tick();
    en = 4'hF;
    for (int c = 0; c < CH; c++) npd[c] = 0;
    repeat (64) begin
      tick();
      for (int c = 0; c < CH; c++) npd[c] += int'(pd[c]);
    end
    chk("s5_pd_ch0", 32'(npd[0]), 32'd32);
    chk("s5_pd_ch1", 32'(npd[1]), 32'd16);
    chk("s5_pd_ch2", 32'(npd[2]), 32'd8);
    chk("s5_pd_ch3", 32'(npd[3]), 32'd4);
    en = 4'b1101;
    repeat (24) tick();
    en = 4'hF;
    repeat (16) tick();

    // Randomized enables and selects against the model.
    repeat (300) begin
      for (int c = 0; c < CH; c++) begin
        en[c] = ($urandom_range(7) != 0);
        if ($urandom_range(15) == 0) sel[c*SEL_W +: SEL_W] = 2'($urandom_range(3));
      end
      tick();
    end

    // Asynchronous reset while an output is high.
    en = 4'hF;
    begin
      int w;
      w = 0;
      while (clkOut == 4'd0 && w < 50) begin
        tick();
        w++;
      end
    end
    chk("arst_saw_high", 32'(clkOut != 4'd0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_clkOut", 32'(clkOut), 32'd0);
    chk("arst_pd", 32'(pd), 32'd0);
    model_reset();
    tick();
    reset = 1'b1;
    repeat (40) tick();

    // Wide configuration: ratio 7 at BASE_HALF=5 -> 640-cycle half-period.
    en = '0;
    sel2 = {3'd0, 3'd7};
    tick();
    en2 = 2'b01;
    begin
      int rise, fall;
      rise = 0; fall = 0;
      for (int n = 1; n <= 1400 && fall == 0; n++) begin
        tick();
        if (rise == 0 && clkOut2[0]) rise = n;
        if (pd2[0]) begin
          fall = n;
          chk("w_fall_clk", 32'(clkOut2[0]), 32'd0);
        end
      end
      chk("w_first_rise", 32'(rise), 32'd640);
      chk("w_period_done", 32'(fall), 32'd1280);
      chk("w_ch1_idle", 32'({clkOut2[1], pd2[1]}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
